// File: rtl/blink_period_meter.sv
// Measures the half-period of an asynchronous toggling input in CLOCK_50 cycles
// and delivers each measurement on a valid/ready port with overrun and timeout flags.
module blink_period_meter #(
    parameter int CNT_W   = 26,
    parameter int MAX_CNT = 50000000
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             LED_IN,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             overrun,
    output logic             timeout,
    output logic             level
);

    localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_CNT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_STALL   = 2'd2
    } state_t;

    state_t           state_r;
    logic             sync1_r;
    logic             sync2_r;
    logic             hist_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] period_r;
    logic             valid_r;
    logic             overrun_r;
    logic             timeout_r;
    logic             edge_s;
    logic             report_s;

    // Two-flop synchronizer plus one history flop for transition detection
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            hist_r  <= 1'b0;
        end else begin
            sync1_r <= LED_IN;
            sync2_r <= sync1_r;
            hist_r  <= sync2_r;
        end
    end

    // Transition strobe and report qualifier: only a referenced edge is reported
    always_comb begin
        edge_s   = sync2_r ^ hist_r;
        report_s = 1'b0;
        if (edge_s && (state_r == ST_MEASURE)) begin
            report_s = 1'b1;
        end else begin
            report_s = 1'b0;
        end
    end

    // Measurement FSM with interval counter and output handshake
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= ZERO_C;
            period_r  <= ZERO_C;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (edge_s) begin
                        state_r <= ST_MEASURE;
                        cnt_r   <= ONE_C;
                    end
                end
                ST_MEASURE: begin
                    // An edge landing exactly at MAX_CNT wins over the timeout
                    if (edge_s) begin
                        cnt_r <= ONE_C;
                    end else if (cnt_r == MAX_C) begin
                        state_r   <= ST_STALL;
                        timeout_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + ONE_C;
                    end
                end
                ST_STALL: begin
                    if (edge_s) begin
                        state_r   <= ST_MEASURE;
                        cnt_r     <= ONE_C;
                        timeout_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= ZERO_C;
                    timeout_r <= 1'b0;
                end
            endcase

            if (report_s) begin
                period_r <= cnt_r;
                valid_r  <= 1'b1;
                if (valid_r && !period_ready) begin
                    overrun_r <= 1'b1;
                end
            end else if (valid_r && period_ready) begin
                valid_r <= 1'b0;
            end
        end
    end

    assign period       = period_r;
    assign period_valid = valid_r;
    assign overrun      = overrun_r;
    assign timeout      = timeout_r;
    assign level        = sync2_r;

endmodule

// File: tb/tb_blink_period_meter.sv
// Randomized bench for blink_period_meter: a timestamp-based reference model feeds
// a scoreboard queue that a negedge monitor drains on every handshake.
module tb_blink_period_meter;

    localparam int CNT_W   = 26;
    localparam int MAX_CNT = 100;

    logic             clk = 1'b0;
    logic             rst;
    logic             led;
    logic             ready;
    logic [CNT_W-1:0] period;
    logic             valid;
    logic             overrun;
    logic             timeout;
    logic             level;

    int checks = 0;
    int errors = 0;

    // scoreboard of periods the DUT is expected to present
    int q_exp[$];

    // reference model state: edge timestamps, not RTL state
    longint           n = 0;
    bit               started = 1'b0;
    bit               prev_smp, lvl_next;
    longint           ev_q[$];
    bit               has_ref;
    longint           last;
    bit               pend, ovr_e, tmo_e, lvl_e;
    logic [CNT_W-1:0] per_e;
    bit               m_ev, m_rep;

    blink_period_meter #(.CNT_W(CNT_W), .MAX_CNT(MAX_CNT)) dut (
        .CLOCK_50     (clk),
        .reset        (rst),
        .LED_IN       (led),
        .period       (period),
        .period_valid (valid),
        .period_ready (ready),
        .overrun      (overrun),
        .timeout      (timeout),
        .level        (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: a sampled input change at edge k becomes an event at edge k+2;
    // consecutive events no more than MAX_CNT apart yield a report of their distance.
    always @(posedge clk) begin
        #1;
        n++;
        started = 1'b1;
        if (!rst) begin
            ev_q.delete();
            q_exp.delete();
            prev_smp = 1'b0;
            lvl_next = 1'b0;
            lvl_e    = 1'b0;
            has_ref  = 1'b0;
            pend     = 1'b0;
            ovr_e    = 1'b0;
            tmo_e    = 1'b0;
            per_e    = '0;
        end else begin
            lvl_e    = lvl_next;
            lvl_next = led;
            if (led != prev_smp) begin
                ev_q.push_back(n + 2);
                prev_smp = led;
            end
            m_ev = 1'b0;
            if (ev_q.size() > 0 && ev_q[0] == n) begin
                m_ev = 1'b1;
                void'(ev_q.pop_front());
            end
            m_rep = m_ev && has_ref && ((n - last) <= MAX_CNT);
            if (m_rep) begin
                if (pend && !ready) begin
                    ovr_e = 1'b1;
                    if (q_exp.size() > 0) void'(q_exp.pop_back());
                end
                q_exp.push_back(int'(n - last));
                per_e = CNT_W'(n - last);
                pend  = 1'b1;
            end else if (pend && ready) begin
                pend = 1'b0;
            end
            if (m_ev) begin
                tmo_e   = 1'b0;
                last    = n;
                has_ref = 1'b1;
            end else begin
                tmo_e = has_ref && ((n - last) >= MAX_CNT);
            end
        end
    end

    // Monitor: compare flags every cycle and pop the scoreboard on each handshake
    always @(negedge clk) begin
        if (started) begin
            check("period_valid", {63'd0, valid}, {63'd0, pend});
            check("overrun", {63'd0, overrun}, {63'd0, ovr_e});
            check("timeout", {63'd0, timeout}, {63'd0, tmo_e});
            check("level", {63'd0, level}, {63'd0, lvl_e});
            check("period_hold", 64'(period), 64'(per_e));
            if (valid === 1'b1) begin
                if (q_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty at t=%0t: got valid period %0d expected no report", $time, period);
                end else begin
                    check("sb_period", 64'(period), 64'(q_exp[0]));
                    if (ready) void'(q_exp.pop_front());
                end
            end
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    task automatic toggle_after(input int gap);
        tick(gap);
        led = ~led;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b0;
        led   = 1'b0;
        ready = 1'b1;
        tick(3);
        rst = 1'b1;
        led = 1'b1;
        tick(5);

        // steady blink with the consumer always ready
        repeat (6) toggle_after(50);

        // backpressure: second report overwrites the first
        ready = 1'b0;
        toggle_after(40);
        toggle_after(20);
        tick(5);
        ready = 1'b1;
        tick(3);

        // timeout then re-arm, exact MAX_CNT interval, single-cycle glitch
        toggle_after(150);
        toggle_after(30);
        toggle_after(100);
        toggle_after(1);
        toggle_after(1);
        toggle_after(20);

        // reset with a pending report
        ready = 1'b0;
        toggle_after(20);
        tick(2);
        rst = 1'b0;
        tick(1);
        rst   = 1'b1;
        ready = 1'b1;
        toggle_after(10);
        toggle_after(50);

        // randomized intervals, backpressure and occasional resets
        for (int i = 0; i < 300; i++) begin
            int cat;
            int gap;
            cat = int'($urandom_range(0, 9));
            case (cat)
                0, 1, 2: gap = int'($urandom_range(1, 4));
                3, 4, 5, 6: gap = int'($urandom_range(20, 99));
                7: gap = MAX_CNT;
                8: gap = int'($urandom_range(101, 130));
                default: gap = int'($urandom_range(1, 60));
            endcase
            ready = 1'($urandom_range(0, 1));
            toggle_after(gap);
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b0;
                tick(1);
                rst = 1'b1;
            end
        end

        ready = 1'b1;
        tick(200);
        check("sb_drain", 64'(q_exp.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
